dmem_port_arbiter: RTL and testbench

- Sequences the byte-wide dual-port data BRAM and shares it between two requesters: requester 0 is the CPU data-memory path, requester 1 is the loader/debug path.
- Splits each byte, half or word access into port-A/port-B byte beats, collects read bytes into a 32-bit little-endian result, and pulses a per-requester done.
- Sits between the requesters and the mem BRAM shell. busy feeds the pipeline stall input.

---
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter and byte-beat sequencer for the dual-port byte-wide data BRAM.
// Each access is split into port-A/port-B beats; read bytes are assembled little-endian.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter bit          RST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [1:0]        width0,
    input  logic [1:0]        width1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic [31:0]       rdata,
    output logic              done0,
    output logic              done1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              en,
    output logic              wea,
    output logic              web,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [7:0]        data_a,
    output logic [7:0]        data_b,
    input  logic [7:0]        recv_data_a,
    input  logic [7:0]        recv_data_b
);

    typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_RD, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [1:0]        width_q, width_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [31:0]       rd_q, rd_d;
    logic              sel;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prio_q  <= RST_PRIO;
            gnt_q   <= 2'b00;
            we_q    <= 1'b0;
            width_q <= 2'b00;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        width_d = width_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        sel     = 1'b0;
        en      = 1'b0;
        wea     = 1'b0;
        web     = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        done0   = 1'b0;
        done1   = 1'b0;
        rdata   = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                // Contention resolved by prio; any accept hands prio to the other side.
                if (req0 || req1) begin
                    sel     = (req0 && req1) ? prio_q : req1;
                    prio_d  = ~sel;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    we_d    = sel ? we1 : we0;
                    width_d = sel ? width1 : width0;
                    addr_d  = sel ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
                    wd_d    = sel ? wdata1 : wdata0;
                    rd_d    = 32'h0;
                    state_d = S_B0;
                end
            end
            S_B0: begin
                en      = 1'b1;
                addr_a  = addr_q;
                addr_b  = addr_q + ADDR_W'(1);
                data_a  = wd_q[7:0];
                data_b  = wd_q[15:8];
                wea     = we_q;
                web     = we_q && (width_q != 2'b00);
                state_d = width_q[1] ? S_B1 : (we_q ? S_DONE : S_RD);
            end
            S_B1: begin
                en      = 1'b1;
                addr_a  = addr_q + ADDR_W'(2);
                addr_b  = addr_q + ADDR_W'(3);
                data_a  = wd_q[23:16];
                data_b  = wd_q[31:24];
                wea     = we_q;
                web     = we_q;
                if (!we_q) rd_d[15:0] = {recv_data_b, recv_data_a};
                state_d = we_q ? S_DONE : S_RD;
            end
            S_RD: begin
                case (width_q)
                    2'b00:   rd_d = {24'h0, recv_data_a};
                    2'b01:   rd_d = {16'h0, recv_data_b, recv_data_a};
                    default: rd_d = {recv_data_b, recv_data_a, rd_q[15:0]};
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                done0   = gnt_q[0];
                done1   = gnt_q[1];
                rdata   = we_q ? 32'h0 : rd_q;
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural dual-port byte BRAM.
module tb_dmem_port_arbiter;

    logic        clk, rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  width0, width1;
    logic [31:0] rdata;
    logic        done0, done1, busy, en, wea, web;
    logic [1:0]  gnt;
    logic [11:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b, recv_a, recv_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:4095];
    logic [11:0] s_aa [1:8], s_ab [1:8];
    logic [7:0]  s_da [1:8], s_db [1:8];
    logic        s_en [1:8], s_wa [1:8], s_wb [1:8];
    logic [1:0]  s_gnt [1:8];

    dmem_port_arbiter #(.ADDR_W(12), .RST_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .width0(width0), .width1(width1),
        .wdata0(wdata0), .wdata1(wdata1),
        .rdata(rdata), .done0(done0), .done1(done1), .gnt(gnt), .busy(busy),
        .en(en), .wea(wea), .web(web), .addr_a(addr_a), .addr_b(addr_b),
        .data_a(data_a), .data_b(data_b),
        .recv_data_a(recv_a), .recv_data_b(recv_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: contents reload to a known pattern (byte i = i ^ 0x55) while in reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h55;
        end else if (en) begin
            if (wea) mem[addr_a] <= data_a;
            if (web) mem[addr_b] <= data_b;
            recv_a <= mem[addr_a];
            recv_b <= mem[addr_b];
        end
    end

    // Issues one request from an idle DUT; cycle 1 is the first cycle after the accept edge.
    task automatic run_txn(input int who, input logic we, input logic [31:0] addr,
                           input logic [1:0] width, input logic [31:0] wd, input int drop_at,
                           output int lat, output logic [31:0] rd, output logic [1:0] dn);
        if (who == 0) begin
            req0 = 1; we0 = we; addr0 = addr; width0 = width; wdata0 = wd;
        end else begin
            req1 = 1; we1 = we; addr1 = addr; width1 = width; wdata1 = wd;
        end
        lat = -1; rd = 32'hDEADBEEF; dn = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s_aa[c] = addr_a; s_ab[c] = addr_b; s_da[c] = data_a; s_db[c] = data_b;
            s_en[c] = en; s_wa[c] = wea; s_wb[c] = web; s_gnt[c] = gnt;
            if (c == drop_at) begin
                if (who == 0) begin req0 = 0; addr0 = ~addr; wdata0 = ~wd; end
                else begin req1 = 0; addr1 = ~addr; wdata1 = ~wd; end
            end
            if (done0 || done1) begin
                lat = c; rd = rdata; dn = {done1, done0};
                break;
            end
        end
        if (who == 0) req0 = 0; else req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        checks++; if ({en, wea, web, busy, done0, done1} !== 6'b0) begin errors++; $display("FAIL rst_ctl got %b want 000000", {en, wea, web, busy, done0, done1}); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", gnt); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
        checks++; if ({addr_a, addr_b} !== 24'h0) begin errors++; $display("FAIL rst_addr got %h want 0", {addr_a, addr_b}); end
        checks++; if ({data_a, data_b} !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0", {data_a, data_b}); end
        rst = 1;
        @(negedge clk);
        checks++; if ({busy, gnt} !== 3'b0) begin errors++; $display("FAIL idle_after_rst got %b want 000", {busy, gnt}); end
    endtask

    task automatic test_contention;
        int order [4];
        int n, need0, need1, ov;
        rst = 0; @(negedge clk); rst = 1;
        we0 = 1; addr0 = 32'h100; width0 = 2'b00; wdata0 = 32'h11;
        we1 = 1; addr1 = 32'h101; width1 = 2'b00; wdata1 = 32'h22;
        req0 = 1; req1 = 1;
        n = 0; need0 = 2; need1 = 2; ov = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (done0 && done1) ov++;
            if (done0) begin
                if (n < 4) order[n] = 0;
                n++; need0--; req0 = 0;
            end else if (!req0 && need0 > 0) req0 = 1;
            if (done1) begin
                if (n < 4) order[n] = 1;
                n++; need1--; req1 = 0;
            end else if (!req1 && need1 > 0) req1 = 1;
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        checks++; if (n !== 4) begin errors++; $display("FAIL cont_count got %0d want 4", n); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL cont_overlap got %0d want 0", ov); end
        checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
            errors++; $display("FAIL cont_order got %0d %0d %0d %0d want 0 1 0 1", order[0], order[1], order[2], order[3]);
        end
    endtask

    task automatic test_word_write;
        int lat; logic [31:0] rd; logic [1:0] dn;
        run_txn(0, 1'b1, 32'h10, 2'b10, 32'hA1B2C3D4, 0, lat, rd, dn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ww_lat got %0d want 3", lat); end
        checks++; if (dn !== 2'b01) begin errors++; $display("FAIL ww_done got %b want 01", dn); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ww_rdata got %h want 0", rd); end
        checks++; if (s_gnt[1] !== 2'b01) begin errors++; $display("FAIL ww_gnt got %b want 01", s_gnt[1]); end
        checks++; if ({s_en[1], s_wa[1], s_wb[1]} !== 3'b111) begin errors++; $display("FAIL ww_b0_we got %b want 111", {s_en[1], s_wa[1], s_wb[1]}); end
        checks++; if ({s_aa[1], s_ab[1]} !== {12'h010, 12'h011}) begin errors++; $display("FAIL ww_b0_addr got %h want 010011", {s_aa[1], s_ab[1]}); end
        checks++; if ({s_da[1], s_db[1]} !== 16'hD4C3) begin errors++; $display("FAIL ww_b0_data got %h want d4c3", {s_da[1], s_db[1]}); end
        checks++; if ({s_en[2], s_wa[2], s_wb[2]} !== 3'b111) begin errors++; $display("FAIL ww_b1_we got %b want 111", {s_en[2], s_wa[2], s_wb[2]}); end
        checks++; if ({s_aa[2], s_ab[2]} !== {12'h012, 12'h013}) begin errors++; $display("FAIL ww_b1_addr got %h want 012013", {s_aa[2], s_ab[2]}); end
        checks++; if ({s_da[2], s_db[2]} !== 16'hB2A1) begin errors++; $display("FAIL ww_b1_data got %h want b2a1", {s_da[2], s_db[2]}); end
        checks++; if ({busy, gnt} !== 3'b0) begin errors++; $display("FAIL ww_idle got %b want 000", {busy, gnt}); end
    endtask

    task automatic test_word_read;
        int lat; logic [31:0] rd; logic [1:0] dn;
        int bad_gnt;
        run_txn(1, 1'b0, 32'h10, 2'b11, 32'h0, 0, lat, rd, dn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL wr_lat got %0d want 4", lat); end
        checks++; if (dn !== 2'b10) begin errors++; $display("FAIL wr_done got %b want 10", dn); end
        checks++; if (rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL wr_rdata got %h want a1b2c3d4", rd); end
        bad_gnt = 0;
        for (int c = 1; c <= 4; c++) if (s_gnt[c] !== 2'b10) bad_gnt++;
        checks++; if (bad_gnt !== 0) begin errors++; $display("FAIL wr_gnt got %0d bad cycles want 0", bad_gnt); end
        checks++; if ({s_wa[1], s_wb[1], s_wa[2], s_wb[2]} !== 4'b0) begin errors++; $display("FAIL wr_nowrite got %b want 0000", {s_wa[1], s_wb[1], s_wa[2], s_wb[2]}); end
        checks++; if ({s_en[2], s_en[3]} !== 2'b10) begin errors++; $display("FAIL wr_en got %b want 10", {s_en[2], s_en[3]}); end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic [1:0] dn;
        run_txn(0, 1'b1, 32'hFFF, 2'b00, 32'h0000005A, 0, lat, rd, dn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL bw_lat got %0d want 2", lat); end
        checks++; if ({s_wa[1], s_wb[1]} !== 2'b10) begin errors++; $display("FAIL bw_we got %b want 10", {s_wa[1], s_wb[1]}); end
        checks++; if ({s_aa[1], s_da[1]} !== {12'hFFF, 8'h5A}) begin errors++; $display("FAIL bw_beat got %h want fff5a", {s_aa[1], s_da[1]}); end
        run_txn(0, 1'b0, 32'hFFFF_FFFF, 2'b01, 32'h0, 0, lat, rd, dn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL hr_lat got %0d want 3", lat); end
        checks++; if ({s_aa[1], s_ab[1]} !== {12'hFFF, 12'h000}) begin errors++; $display("FAIL hr_wrap got %h want fff000", {s_aa[1], s_ab[1]}); end
        checks++; if (rd !== 32'h0000555A) begin errors++; $display("FAIL hr_rdata got %h want 0000555a", rd); end
        run_txn(1, 1'b0, 32'h13, 2'b00, 32'h0, 0, lat, rd, dn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL br_lat got %0d want 3", lat); end
        checks++; if (rd !== 32'h000000A1) begin errors++; $display("FAIL br_rdata got %h want 000000a1", rd); end
    endtask

    task automatic test_req_drop;
        int lat; logic [31:0] rd; logic [1:0] dn;
        run_txn(0, 1'b1, 32'h20, 2'b01, 32'h00007788, 1, lat, rd, dn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL drop_lat got %0d want 2", lat); end
        checks++; if (dn !== 2'b01) begin errors++; $display("FAIL drop_done got %b want 01", dn); end
        checks++; if ({s_wb[1], s_da[1], s_db[1]} !== {1'b1, 16'h8877}) begin errors++; $display("FAIL drop_beat got %h want 18877", {s_wb[1], s_da[1], s_db[1]}); end
        run_txn(1, 1'b0, 32'h20, 2'b01, 32'h0, 0, lat, rd, dn);
        checks++; if (rd !== 32'h00007788) begin errors++; $display("FAIL drop_readback got %h want 00007788", rd); end
    endtask

    task automatic test_reset_midflight;
        int seen, d0;
        req0 = 1; we0 = 0; addr0 = 32'h10; width0 = 2'b10;
        @(negedge clk); @(negedge clk);
        checks++; if ({en, gnt} !== 3'b101) begin errors++; $display("FAIL mid_b1 got %b want 101", {en, gnt}); end
        rst = 0;
        #1;
        checks++; if ({en, wea, web, busy, done0, done1, gnt} !== 8'b0) begin errors++; $display("FAIL mid_rst_ctl got %b want 0", {en, wea, web, busy, done0, done1, gnt}); end
        checks++; if ({rdata, addr_a, addr_b} !== 56'h0) begin errors++; $display("FAIL mid_rst_bus got %h want 0", {rdata, addr_a, addr_b}); end
        req0 = 0;
        seen = 0;
        repeat (3) begin @(negedge clk); if (done0 || done1) seen++; end
        rst = 1;
        we0 = 0; addr0 = 32'h13; width0 = 2'b00;
        we1 = 0; addr1 = 32'h10; width1 = 2'b00;
        req0 = 1; req1 = 1;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_prio got %b want 01", gnt); end
        req0 = 0; req1 = 0;
        d0 = 0;
        repeat (5) begin @(negedge clk); if (done0) d0++; if (done1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stray_done got %0d want 0", seen); end
        checks++; if (d0 !== 1) begin errors++; $display("FAIL mid_done0 got %0d want 1", d0); end
    endtask

    initial begin
        rst = 0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; width0 = 0; width1 = 0; wdata0 = 0; wdata1 = 0;
        test_reset;
        test_contention;
        test_word_write;
        test_word_read;
        test_wrap;
        test_req_drop;
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
